ps2_numeric_field: RTL and testbench

Parametrised PS/2 numeric entry field: collects decimal digits from the keyboard byte stream while enabled, supports backspace/escape, converts on Enter, clamps to a legal range, and drives the committed value plus seven-segment digits. It is the generic successor of the per-mode loop and BPM entry blocks and sits beside the mode controller, one instance per editable quantity.

---
 rtl/ps2_keys_pkg.sv | 62 ++++++
 rtl/bcd_to_seg7.sv | 30 +++
 rtl/ps2_numeric_field.sv | 219 +++++++++++++++++++++
 tb/tb_ps2_numeric_field.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_keys_pkg.sv
// Purpose: shared PS/2 set-2 scan codes, numeric-field state encoding and BCD helper.
// Latency: none (constants and constant functions only).
// Backpressure: not applicable.
package ps2_keys_pkg;

  // Set-2 make codes for the main-row digit keys
  localparam logic [7:0] KEY_0 = 8'h45;
  localparam logic [7:0] KEY_1 = 8'h16;
  localparam logic [7:0] KEY_2 = 8'h1E;
  localparam logic [7:0] KEY_3 = 8'h26;
  localparam logic [7:0] KEY_4 = 8'h25;
  localparam logic [7:0] KEY_5 = 8'h2E;
  localparam logic [7:0] KEY_6 = 8'h36;
  localparam logic [7:0] KEY_7 = 8'h3D;
  localparam logic [7:0] KEY_8 = 8'h3E;
  localparam logic [7:0] KEY_9 = 8'h46;

  // Prefix and editing keys
  localparam logic [7:0] KEY_BREAK = 8'hF0;
  localparam logic [7:0] KEY_EXT   = 8'hE0;
  localparam logic [7:0] KEY_ENTER = 8'h5A;
  localparam logic [7:0] KEY_BKSP  = 8'h66;
  localparam logic [7:0] KEY_ESC   = 8'h76;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EDIT,
    ST_BREAK,
    ST_CONVERT
  } field_state_t;

  // Integer to BCD, four nibbles (largest supported field); callers keep the low DIGITS nibbles.
  function automatic logic [15:0] to_bcd(input int unsigned val);
    logic [15:0] r;
    int unsigned v;
    r = '0;
    v = val;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // Digit decode: {is_digit, value}
  function automatic logic [4:0] key_digit(input logic [7:0] code);
    case (code)
      KEY_0:   return 5'h10;
      KEY_1:   return 5'h11;
      KEY_2:   return 5'h12;
      KEY_3:   return 5'h13;
      KEY_4:   return 5'h14;
      KEY_5:   return 5'h15;
      KEY_6:   return 5'h16;
      KEY_7:   return 5'h17;
      KEY_8:   return 5'h18;
      KEY_9:   return 5'h19;
      default: return 5'h00;
    endcase
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Purpose: one BCD digit to active-low seven-segment pattern (gfedcba), with blanking.
// Latency: combinational.
// Backpressure: not applicable.
module bcd_to_seg7 (
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [6:0] seg
);

  // Segment lookup; non-decimal codes and blanked positions show all segments off
  always_comb begin
    seg = 7'h7F;
    if (!blank) begin
      case (bcd)
        4'd0:    seg = 7'h40;
        4'd1:    seg = 7'h79;
        4'd2:    seg = 7'h24;
        4'd3:    seg = 7'h30;
        4'd4:    seg = 7'h19;
        4'd5:    seg = 7'h12;
        4'd6:    seg = 7'h02;
        4'd7:    seg = 7'h78;
        4'd8:    seg = 7'h00;
        4'd9:    seg = 7'h10;
        default: seg = 7'h7F;
      endcase
    end
  end

endmodule

// File: rtl/ps2_numeric_field.sv
// Purpose: PS/2 decimal entry field with backspace/escape, convert-on-Enter, range clamp and 7-seg drive.
// Latency: key byte acts one edge after its strobe; Enter commits DIGITS+1 edges after its strobe.
// Backpressure: none; the byte stream cannot be stalled, bytes arriving while converting are dropped.
module ps2_numeric_field
  import ps2_keys_pkg::*;
#(
  parameter int DIGITS    = 3,
  parameter int WIDTH     = 10,
  parameter int MIN_VAL   = 1,
  parameter int MAX_VAL   = 999,
  parameter int INIT_VAL  = 120,
  parameter int BLINK_DIV = 1_250_000
) (
  input  logic                  CLOCK_50,
  input  logic                  nReset,
  input  logic                  Enable,
  input  logic [7:0]            data,
  input  logic                  data_en,
  output logic [WIDTH-1:0]      Value,
  output logic                  Commit,
  output logic                  Error,
  output logic                  Editing,
  output logic                  Blink,
  output logic [7*DIGITS-1:0]   HEX
);

  localparam int BW  = 4 * DIGITS;
  localparam int BCW = $clog2(BLINK_DIV + 1);
  localparam logic [BW-1:0] INIT_BCD = BW'(to_bcd(INIT_VAL));
  localparam logic [BW-1:0] MIN_BCD  = BW'(to_bcd(MIN_VAL));
  localparam logic [BW-1:0] MAX_BCD  = BW'(to_bcd(MAX_VAL));
  localparam logic [2:0]    CNT_MAX  = 3'(DIGITS);
  localparam logic [1:0]    LAST_STEP = 2'(DIGITS - 1);

  field_state_t     state_q, state_d;
  logic [BW-1:0]    buf_q, buf_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [BW-1:0]    acc_q, acc_d;
  logic [1:0]       step_q, step_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic [BW-1:0]    shadow_q, shadow_d;
  logic             commit_q, commit_d;
  logic             error_q, error_d;
  logic [BCW-1:0]   blink_cnt_q, blink_cnt_d;
  logic             blink_q, blink_d;

  logic [4:0]  key_dig;
  logic [3:0]  nib;
  logic [31:0] acc_wide;
  logic        editing;

  assign editing = (state_q == ST_EDIT) || (state_q == ST_CONVERT);

  // State, buffer, accumulator and committed-value registers
  always_ff @(posedge CLOCK_50 or negedge nReset) begin
    if (!nReset) begin
      state_q     <= ST_IDLE;
      buf_q       <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
      step_q      <= '0;
      value_q     <= WIDTH'(INIT_VAL);
      shadow_q    <= INIT_BCD;
      commit_q    <= 1'b0;
      error_q     <= 1'b0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      step_q      <= step_d;
      value_q     <= value_d;
      shadow_q    <= shadow_d;
      commit_q    <= commit_d;
      error_q     <= error_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
    end
  end

  // Next-state: key handling in EDIT, MSB-first decimal accumulation in CONVERT, abort on Enable low
  always_comb begin
    state_d  = state_q;
    buf_d    = buf_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    step_d   = step_q;
    value_d  = value_q;
    shadow_d = shadow_q;
    commit_d = 1'b0;
    error_d  = 1'b0;

    key_dig = key_digit(data);

    // Nibble for this conversion step, most significant first
    nib = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (step_q == 2'(DIGITS - 1 - i)) nib = buf_q[4*i +: 4];
    end
    acc_wide = 32'(acc_q) * 32'd10 + 32'(nib);

    if ((state_q != ST_IDLE) && !Enable) begin
      state_d = ST_IDLE;
      buf_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (Enable) begin
            state_d = ST_EDIT;
            buf_d   = '0;
            cnt_d   = '0;
          end
        end
        ST_EDIT: begin
          if (data_en) begin
            if (key_dig[4]) begin
              if (cnt_q == CNT_MAX) begin
                error_d = 1'b1;
              end else begin
                buf_d = (buf_q << 4) | BW'(key_dig[3:0]);
                cnt_d = cnt_q + 3'd1;
              end
            end else begin
              case (data)
                KEY_BREAK: state_d = ST_BREAK;
                // Extended prefix carries no meaning here; the following byte is decoded normally
                KEY_EXT: ;
                KEY_BKSP: begin
                  if (cnt_q == 3'd0) begin
                    error_d = 1'b1;
                  end else begin
                    buf_d = buf_q >> 4;
                    cnt_d = cnt_q - 3'd1;
                  end
                end
                KEY_ESC: begin
                  buf_d = '0;
                  cnt_d = '0;
                end
                KEY_ENTER: begin
                  if (cnt_q != 3'd0) begin
                    state_d = ST_CONVERT;
                    acc_d   = '0;
                    step_d  = '0;
                  end
                end
                default: ;
              endcase
            end
          end
        end
        ST_BREAK: begin
          if (data_en) state_d = ST_EDIT;
        end
        ST_CONVERT: begin
          acc_d  = acc_wide[BW-1:0];
          step_d = step_q + 2'd1;
          if (step_q == LAST_STEP) begin
            commit_d = 1'b1;
            if (acc_wide < 32'(MIN_VAL)) begin
              value_d  = WIDTH'(MIN_VAL);
              shadow_d = MIN_BCD;
              error_d  = 1'b1;
            end else if (acc_wide > 32'(MAX_VAL)) begin
              value_d  = WIDTH'(MAX_VAL);
              shadow_d = MAX_BCD;
              error_d  = 1'b1;
            end else begin
              value_d  = WIDTH'(acc_wide);
              shadow_d = buf_q;
            end
            buf_d   = '0;
            cnt_d   = '0;
            state_d = ST_EDIT;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Blink divider: free-runs while editing, parked at count 0 / LED on otherwise
  always_comb begin
    blink_cnt_d = '0;
    blink_d     = 1'b1;
    if (editing) begin
      if (blink_cnt_q == BCW'(BLINK_DIV - 1)) begin
        blink_cnt_d = '0;
        blink_d     = ~blink_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
        blink_d     = blink_q;
      end
    end
  end

  assign Value   = value_q;
  assign Commit  = commit_q;
  assign Error   = error_q;
  assign Editing = editing;
  assign Blink   = editing ? blink_q : 1'b1;

  // Display: committed shadow when idle, otherwise the typed digits with unused positions blank
  for (genvar g = 0; g < DIGITS; g++) begin : g_seg
    logic [3:0] seg_nib;
    logic       seg_blank;
    assign seg_nib   = (state_q == ST_IDLE) ? shadow_q[4*g +: 4] : buf_q[4*g +: 4];
    assign seg_blank = (state_q != ST_IDLE) && (cnt_q <= 3'(g));
    bcd_to_seg7 u_seg (
      .bcd   (seg_nib),
      .blank (seg_blank),
      .seg   (HEX[7*g +: 7])
    );
  end

endmodule

// File: tb/tb_ps2_numeric_field.sv
// Purpose: self-checking bench for ps2_numeric_field; two instances (MAX_VAL 999 and 200) against a decimal model.
// Latency: model commits DIGITS edges after the Enter byte is taken.
// Backpressure: not applicable.
module tb_ps2_numeric_field;

  localparam int D    = 3;
  localparam int W    = 10;
  localparam int BDIV = 16;

  localparam int M_IDLE = 0;
  localparam int M_EDIT = 1;
  localparam int M_BRK  = 2;
  localparam int M_CONV = 3;

  logic           CLOCK_50 = 1'b0;
  logic           nReset   = 1'b1;
  logic           Enable   = 1'b0;
  logic           data_en  = 1'b0;
  logic [7:0]     data     = 8'h00;
  logic [W-1:0]   val1, val2;
  logic           com1, com2, err1, err2, ed1, ed2, blk1, blk2;
  logic [7*D-1:0] hex1, hex2;

  ps2_numeric_field #(.BLINK_DIV(BDIV)) dut1 (
    .CLOCK_50 (CLOCK_50), .nReset (nReset), .Enable (Enable), .data (data), .data_en (data_en),
    .Value (val1), .Commit (com1), .Error (err1), .Editing (ed1), .Blink (blk1), .HEX (hex1)
  );

  ps2_numeric_field #(.MAX_VAL(200), .BLINK_DIV(BDIV)) dut2 (
    .CLOCK_50 (CLOCK_50), .nReset (nReset), .Enable (Enable), .data (data), .data_en (data_en),
    .Value (val2), .Commit (com2), .Error (err2), .Editing (ed2), .Blink (blk2), .HEX (hex2)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int checks   = 0;
  int failures = 0;
  int commits1 = 0;
  int commits2 = 0;

  int keymap[10]   = '{'h45, 'h16, 'h1E, 'h26, 'h25, 'h2E, 'h36, 'h3D, 'h3E, 'h46};
  int seg_tab[10]  = '{'h40, 'h79, 'h24, 'h30, 'h19, 'h12, 'h02, 'h78, 'h00, 'h10};

  // Reference model: typed number plus digit count, committed value, pending conversion countdown
  int m_st[2], m_num[2], m_cnt[2], m_left[2], m_val[2], m_max[2], m_com[2], m_err[2];

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int digit_of(input int code);
    for (int k = 0; k < 10; k++) if (keymap[k] == code) return k;
    return -1;
  endfunction

  // Segments of the low ndig decimal digits of num, remaining positions blank
  function automatic int hex_of(input int num, input int ndig);
    int r;
    r = 0;
    for (int i = 0; i < D; i++) begin
      if (i < ndig) r = r | (seg_tab[(num / (10 ** i)) % 10] << (7 * i));
      else          r = r | ('h7F << (7 * i));
    end
    return r;
  endfunction

  function automatic int exp_hex(input int i);
    if (m_st[i] == M_IDLE) return hex_of(m_val[i], D);
    return hex_of(m_num[i], m_cnt[i]);
  endfunction

  task automatic reset_model();
    for (int i = 0; i < 2; i++) begin
      m_st[i] = M_IDLE; m_num[i] = 0; m_cnt[i] = 0; m_left[i] = 0;
      m_val[i] = 120; m_com[i] = 0; m_err[i] = 0;
    end
    m_max[0] = 999;
    m_max[1] = 200;
  endtask

  task automatic model_step(input bit en, input bit de, input int d);
    int dv;
    for (int i = 0; i < 2; i++) begin
      m_com[i] = 0;
      m_err[i] = 0;
      if (m_st[i] != M_IDLE && !en) begin
        m_st[i] = M_IDLE; m_num[i] = 0; m_cnt[i] = 0;
      end else begin
        case (m_st[i])
          M_IDLE: if (en) begin m_st[i] = M_EDIT; m_num[i] = 0; m_cnt[i] = 0; end
          M_EDIT: if (de) begin
            dv = digit_of(d);
            if (dv >= 0) begin
              if (m_cnt[i] == D) m_err[i] = 1;
              else begin m_num[i] = m_num[i] * 10 + dv; m_cnt[i]++; end
            end else if (d == 'hF0) m_st[i] = M_BRK;
            else if (d == 'h66) begin
              if (m_cnt[i] == 0) m_err[i] = 1;
              else begin m_num[i] = m_num[i] / 10; m_cnt[i]--; end
            end else if (d == 'h76) begin m_num[i] = 0; m_cnt[i] = 0; end
            else if (d == 'h5A && m_cnt[i] > 0) begin m_st[i] = M_CONV; m_left[i] = D; end
          end
          M_BRK: if (de) m_st[i] = M_EDIT;
          default: begin
            m_left[i]--;
            if (m_left[i] == 0) begin
              m_com[i] = 1;
              if (m_num[i] < 1) begin m_val[i] = 1; m_err[i] = 1; end
              else if (m_num[i] > m_max[i]) begin m_val[i] = m_max[i]; m_err[i] = 1; end
              else m_val[i] = m_num[i];
              m_num[i] = 0; m_cnt[i] = 0; m_st[i] = M_EDIT;
            end
          end
        endcase
      end
    end
  endtask

  task automatic cmp_inst(input int i, input int v, input int c, input int e, input int ed,
                          input int b, input int h);
    int med;
    med = (m_st[i] == M_EDIT || m_st[i] == M_CONV) ? 1 : 0;
    chk($sformatf("value%0d", i), v, m_val[i]);
    chk($sformatf("commit%0d", i), c, m_com[i]);
    chk($sformatf("error%0d", i), e, m_err[i]);
    chk($sformatf("editing%0d", i), ed, med);
    chk($sformatf("hex%0d", i), h, exp_hex(i));
    if (med == 0) chk($sformatf("blink_idle%0d", i), b, 1);
  endtask

  task automatic compare_all();
    cmp_inst(0, int'(val1), int'(com1), int'(err1), int'(ed1), int'(blk1), int'(hex1));
    cmp_inst(1, int'(val2), int'(com2), int'(err2), int'(ed2), int'(blk2), int'(hex2));
  endtask

  // One clock: model sees the same inputs the DUT samples, outputs checked 1ns later
  task automatic tick();
    @(posedge CLOCK_50);
    model_step(Enable, data_en, int'(data));
    #1;
    if (com1) commits1++;
    if (com2) commits2++;
    compare_all();
  endtask

  task automatic send(input int b);
    data    = 8'(b);
    data_en = 1'b1;
    tick();
    data_en = 1'b0;
    data    = 8'($urandom_range(0, 255));
  endtask

  task automatic press(input int code);
    send(code);
    send('hF0);
    send(code);
  endtask

  task automatic key(input int digit);
    press(keymap[digit]);
  endtask

  task automatic enter_and_wait();
    send('h5A);
    repeat (D) tick();
  endtask

  initial begin
    int c0, h, r, idx;

    reset_model();
    #3 nReset = 1'b0;
    #20;
    compare_all();
    chk("rst_value", int'(val1), 120);
    chk("rst_hex", int'(hex1), hex_of(120, 3));
    chk("rst_blink", int'(blk1), 1);
    chk("rst_commit", int'(com1), 0);
    @(negedge CLOCK_50) nReset = 1'b1;

    // Blink period while sitting in EDIT
    Enable = 1'b1;
    tick();
    for (int k = 0; k < 3 * BDIV; k++) begin
      chk("blink_phase", int'(blk1), ((k / BDIV) % 2 == 0) ? 1 : 0);
      tick();
    end

    // 1,4,0 Enter
    key(1); key(4); key(0);
    c0 = commits1;
    send('h5A);
    repeat (D - 1) tick();
    chk("c140_early", int'(com1), 0);
    tick();
    chk("c140_commit", int'(com1), 1);
    chk("v140", int'(val1), 140);
    chk("e140", int'(err1), 0);
    tick();
    chk("c140_once", commits1 - c0, 1);
    Enable = 1'b0;
    tick();
    chk("ed_off", int'(ed1), 0);
    chk("hex140", int'(hex1), hex_of(140, 3));

    // 2,5,Backspace,7 Enter; then a rejected fourth digit
    Enable = 1'b1;
    tick();
    key(2); key(5); press('h66); key(7);
    enter_and_wait();
    chk("v27", int'(val1), 27);
    key(1); key(2); key(3);
    h = int'(hex1);
    send(keymap[4]);
    chk("err4", int'(err1), 1);
    chk("hex4_kept", int'(hex1), h);
    send('hF0); send(keymap[4]);
    press('h76);

    // Below-minimum clamp, and above-maximum on the second instance
    key(0);
    enter_and_wait();
    chk("v_min", int'(val1), 1);
    chk("c_min", int'(com1), 1);
    chk("e_min", int'(err1), 1);
    key(9); key(9); key(9);
    enter_and_wait();
    chk("v_max2", int'(val2), 200);
    chk("e_max2", int'(err2), 1);
    chk("v999", int'(val1), 999);

    // Escape then Enter: nothing committed
    c0 = commits1;
    key(5); key(5); press('h76);
    send('h5A);
    repeat (D + 2) tick();
    chk("esc_nocommit", commits1 - c0, 0);
    chk("esc_value", int'(val1), 999);

    // Abort during CONVERT cycle 2 with a stray byte in cycle 1
    key(1); key(2);
    c0 = commits1;
    send('h5A);
    data = 8'h16; data_en = 1'b1;
    tick();
    data_en = 1'b0;
    Enable = 1'b0;
    tick();
    chk("abort_editing", int'(ed1), 0);
    repeat (D + 1) tick();
    chk("abort_nocommit", commits1 - c0, 0);
    chk("abort_value", int'(val1), 999);

    // Asynchronous reset in the middle of an edit
    Enable = 1'b1;
    tick();
    key(3);
    #3 nReset = 1'b0;
    #1;
    reset_model();
    compare_all();
    chk("arst_value", int'(val1), 120);
    chk("arst_editing", int'(ed1), 0);
    chk("arst_blink", int'(blk1), 1);
    Enable = 1'b0;
    @(negedge CLOCK_50) nReset = 1'b1;

    // Random key stream with occasional Enable changes
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 99);
      if (r < 2) Enable = 1'b0;
      else if (r < 8) Enable = 1'b1;
      if ($urandom_range(0, 2) == 0) begin
        idx = $urandom_range(0, 15);
        if (idx < 10)       send(keymap[idx]);
        else if (idx == 10) send('hF0);
        else if (idx == 11) send('hE0);
        else if (idx == 12) send('h66);
        else if (idx == 13) send('h76);
        else if (idx == 14) send('h5A);
        else                send($urandom_range(0, 255));
      end else begin
        tick();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
